nodf_txn_profiler: RTL and testbench

- Synthesizable transaction profiler that sits directly upstream of the CSV dump stage for non-dataflow HLS modules.
- Watches one module's ap_start/ap_ready/ap_done/ap_continue handshake and timestamps each transaction against a free-running cycle counter.
- Emits one record per completed transaction (id, start, end, latency) into a record FIFO, drained by the dump consumer via valid/ready.
- Reports drain completion after `finish`.

---
 rtl/nodf_prof_pkg.sv | 15 +
 rtl/nodf_txn_profiler_if.sv | 30 +++
 rtl/txn_prof_fifo.sv | 42 ++++
 rtl/nodf_txn_profiler.sv | 97 +++++++++
 tb/tb_nodf_txn_profiler.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nodf_prof_pkg.sv
// nodf_prof_pkg: shared widths, record layout and start-FSM states for the transaction profiler.
package nodf_prof_pkg;
    localparam int CNT_W_DEF = 32;
    localparam int ID_W_DEF  = 16;

    // Record layout at default widths; rec_data is packed in the same field order.
    typedef struct packed {
        logic [ID_W_DEF-1:0]  id;
        logic [CNT_W_DEF-1:0] start_ts;
        logic [CNT_W_DEF-1:0] end_ts;
        logic [CNT_W_DEF-1:0] latency;
    } txn_rec_t;

    typedef enum logic {IDLE, WAIT_READY} start_st_t;
endpackage

// File: rtl/nodf_txn_profiler_if.sv
// nodf_txn_profiler_if: observed ap_ctrl handshake, finish request and record drain bus.
interface nodf_txn_profiler_if
    import nodf_prof_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ID_W  = ID_W_DEF
);
    logic                    ap_start;
    logic                    ap_ready;
    logic                    ap_done;
    logic                    ap_continue;
    logic                    finish;
    logic                    rec_valid;
    logic                    rec_ready;
    logic [ID_W+3*CNT_W-1:0] rec_data;
    logic [15:0]             rec_drop_cnt;
    logic                    err_start_ovf;
    logic                    err_orphan_done;
    logic                    drained;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
        input  rec_valid, rec_data, rec_drop_cnt, err_start_ovf, err_orphan_done, drained
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
        output rec_valid, rec_data, rec_drop_cnt, err_start_ovf, err_orphan_done, drained
    );
endinterface

// File: rtl/txn_prof_fifo.sv
// txn_prof_fifo: show-ahead synchronous FIFO; a write into a full FIFO succeeds when a read happens in the same cycle.
module txn_prof_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          do_wr, do_rd;

    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign dout  = mem[rp];

    always_ff @(posedge clock)
        if (do_wr) mem[wp] <= din;

    always_ff @(posedge clock) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_wr) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
            if (do_rd) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/nodf_txn_profiler.sv
// nodf_txn_profiler: timestamps ap_start/ap_ready against a free-running counter and pairs each
// done with the oldest start stamp, emitting {id, start, end, latency} records into a drain FIFO.
module nodf_txn_profiler
    import nodf_prof_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ID_W      = ID_W_DEF,
    parameter int MAX_OUT   = 4,
    parameter int REC_DEPTH = 8
) (
    input logic                clock,
    input logic                reset,
    nodf_txn_profiler_if.slave bus
);
    localparam int REC_W = ID_W + 3 * CNT_W;

    start_st_t        state, state_nx;
    logic [CNT_W-1:0] cnt, stamp, push_ts, sq_dout, start_ts;
    logic [ID_W-1:0]  txn_id;
    logic [15:0]      drop_cnt;
    logic             ovf_seen, orphan_seen, finish_seen;
    logic             push, done, bypass, pop, orphan, start_ovf, sq_wr, sq_full, sq_empty;
    logic             rec_fire, rf_wr, rf_rd, rf_full, rf_empty, drop;
    logic [REC_W-1:0] rf_dout;

    always_comb begin
        push     = (state == IDLE) ? bus.ap_start & bus.ap_ready : bus.ap_ready;
        push_ts  = (state == IDLE) ? cnt : stamp;
        state_nx = (state == IDLE) ? ((bus.ap_start & ~bus.ap_ready) ? WAIT_READY : IDLE)
                                   : (bus.ap_ready ? IDLE : WAIT_READY);
    end

    // A done on an empty queue consumes a same-cycle push directly instead of queueing it.
    assign done      = bus.ap_done & bus.ap_continue;
    assign pop       = done & ~sq_empty;
    assign bypass    = done & sq_empty & push;
    assign orphan    = done & sq_empty & ~push;
    assign start_ovf = push & sq_full & ~pop;
    assign sq_wr     = push & ~bypass & ~start_ovf;
    assign start_ts  = bypass ? push_ts : sq_dout;
    assign rec_fire  = pop | bypass;
    assign rf_rd     = ~rf_empty & bus.rec_ready;
    assign rf_wr     = rec_fire & (~rf_full | rf_rd);
    assign drop      = rec_fire & ~rf_wr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            stamp       <= '0;
            txn_id      <= '0;
            drop_cnt    <= '0;
            ovf_seen    <= 1'b0;
            orphan_seen <= 1'b0;
            finish_seen <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt + CNT_W'(1);
            if (state == IDLE) stamp <= cnt;
            txn_id      <= txn_id + ID_W'(rec_fire);
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            ovf_seen    <= ovf_seen | start_ovf;
            orphan_seen <= orphan_seen | orphan;
            finish_seen <= finish_seen | bus.finish;
        end
    end

    txn_prof_fifo #(.W(CNT_W), .DEPTH(MAX_OUT)) u_start_q (
        .clock (clock),
        .reset (reset),
        .wr    (sq_wr),
        .rd    (pop),
        .din   (push_ts),
        .dout  (sq_dout),
        .full  (sq_full),
        .empty (sq_empty)
    );

    txn_prof_fifo #(.W(REC_W), .DEPTH(REC_DEPTH)) u_rec_q (
        .clock (clock),
        .reset (reset),
        .wr    (rf_wr),
        .rd    (rf_rd),
        .din   ({txn_id, start_ts, cnt, cnt - start_ts}),
        .dout  (rf_dout),
        .full  (rf_full),
        .empty (rf_empty)
    );

    // Masking stale memory keeps rec_data at zero whenever no record is offered.
    assign bus.rec_valid       = ~rf_empty;
    assign bus.rec_data        = rf_empty ? '0 : rf_dout;
    assign bus.rec_drop_cnt    = drop_cnt;
    assign bus.err_start_ovf   = ovf_seen;
    assign bus.err_orphan_done = orphan_seen;
    assign bus.drained         = finish_seen & rf_empty;
endmodule

// File: tb/tb_nodf_txn_profiler.sv
// tb_nodf_txn_profiler: directed tables, hand-written corner sequences and a random run checked
// against a queue-based model of the profiler; a second 8-bit-counter instance covers wrap.
module tb_nodf_txn_profiler;
    import nodf_prof_pkg::*;

    localparam int MAX_OUT   = 4;
    localparam int REC_DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rst8  = 1'b1;
    always #5 clock = ~clock;

    nodf_txn_profiler_if #(.CNT_W(32), .ID_W(16)) bus ();
    nodf_txn_profiler_if #(.CNT_W(8), .ID_W(16))  bus8 ();

    nodf_txn_profiler #(.CNT_W(32), .ID_W(16), .MAX_OUT(MAX_OUT), .REC_DEPTH(REC_DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    nodf_txn_profiler #(.CNT_W(8), .ID_W(16), .MAX_OUT(MAX_OUT), .REC_DEPTH(REC_DEPTH)) dut8 (
        .clock (clock),
        .reset (rst8),
        .bus   (bus8)
    );

    int checks = 0;
    int errors = 0;
    int c8 = 0;

    // Reference model state
    logic [31:0] m_cnt;
    logic [15:0] m_id;
    logic [15:0] m_drop;
    bit          m_wait, m_ovf, m_orph, m_fs;
    logic [31:0] m_stamp;
    logic [31:0] sq[$];
    txn_rec_t    recq[$];

    typedef struct {
        bit          st, rdy, dn;
        bit          ev;
        logic [15:0] eid;
        logic [31:0] elat;
        bit          eorph;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_id = 0; m_drop = 0;
        m_wait = 0; m_ovf = 0; m_orph = 0; m_fs = 0; m_stamp = 0;
        sq.delete();
        recq.delete();
    endtask

    task automatic model_step();
        bit push, done, have, rd;
        logic [31:0] ts, s;
        txn_rec_t r;
        push = m_wait ? bus.ap_ready : (bus.ap_start && bus.ap_ready);
        ts = m_wait ? m_stamp : m_cnt;
        if (!m_wait && bus.ap_start && !bus.ap_ready) begin
            m_wait = 1;
            m_stamp = m_cnt;
        end else if (m_wait && bus.ap_ready) m_wait = 0;
        done = bus.ap_done && bus.ap_continue;
        rd = recq.size() != 0 && bus.rec_ready;
        have = 0;
        s = 0;
        if (done) begin
            if (sq.size() != 0) begin
                s = sq.pop_front();
                have = 1;
            end else if (push) begin
                s = ts;
                have = 1;
                push = 0;
            end else m_orph = 1;
        end
        if (push) begin
            if (sq.size() < MAX_OUT) sq.push_back(ts);
            else m_ovf = 1;
        end
        if (rd) void'(recq.pop_front());
        if (have) begin
            r = '{id: m_id, start_ts: s, end_ts: m_cnt, latency: m_cnt - s};
            if (recq.size() < REC_DEPTH) recq.push_back(r);
            else if (m_drop != 16'hFFFF) m_drop++;
            m_id++;
        end
        if (bus.finish) m_fs = 1;
        m_cnt++;
    endtask

    task automatic check_model();
        txn_rec_t e;
        e = (recq.size() != 0) ? recq[0] : '0;
        chk("m_rec_valid", bus.rec_valid, recq.size() != 0);
        chk("m_rec_data", bus.rec_data, e);
        chk("m_drop_cnt", bus.rec_drop_cnt, m_drop);
        chk("m_err_start_ovf", bus.err_start_ovf, m_ovf);
        chk("m_err_orphan_done", bus.err_orphan_done, m_orph);
        chk("m_drained", bus.drained, m_fs && recq.size() == 0);
    endtask

    task automatic cyc();
        bit r8;
        r8 = rst8;
        if (reset) model_reset();
        else model_step();
        @(posedge clock);
        #1;
        c8 = r8 ? 0 : c8 + 1;
        check_model();
    endtask

    task automatic idle_in();
        bus.ap_start = 0;
        bus.ap_ready = 0;
        bus.ap_done = 0;
        bus.finish = 0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic idle_to(int n);
        idle_in();
        while (m_cnt < n) cyc();
    endtask

    task automatic chk_rec(string name, logic [15:0] id, logic [31:0] st, logic [31:0] en, logic [31:0] lat);
        txn_rec_t r;
        r = bus.rec_data;
        chk({name, "_valid"}, bus.rec_valid, 1);
        chk({name, "_id"}, r.id, id);
        chk({name, "_start"}, r.start_ts, st);
        chk({name, "_end"}, r.end_ts, en);
        chk({name, "_lat"}, r.latency, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{st: 1, rdy: 1, dn: 1, ev: 1, eid: 0, elat: 0, eorph: 0};
        vecs[1] = '{st: 0, rdy: 0, dn: 0, ev: 0, eid: 0, elat: 0, eorph: 0};
        vecs[2] = '{st: 0, rdy: 0, dn: 1, ev: 0, eid: 0, elat: 0, eorph: 1};
        vecs[3] = '{st: 1, rdy: 0, dn: 0, ev: 0, eid: 0, elat: 0, eorph: 1};
        vecs[4] = '{st: 0, rdy: 1, dn: 1, ev: 1, eid: 1, elat: 1, eorph: 1};
        vecs[5] = '{st: 1, rdy: 1, dn: 0, ev: 0, eid: 0, elat: 0, eorph: 1};
        vecs[6] = '{st: 0, rdy: 0, dn: 1, ev: 1, eid: 2, elat: 1, eorph: 1};

        idle_in();
        bus.ap_continue = 1;
        bus.rec_ready = 1;
        bus8.ap_start = 0; bus8.ap_ready = 0; bus8.ap_done = 0;
        bus8.ap_continue = 1; bus8.finish = 0; bus8.rec_ready = 1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", bus.rec_valid, 0);
        chk("reset_data", bus.rec_data, 0);
        chk("reset_drop", bus.rec_drop_cnt, 0);
        chk("reset_flags", {bus.err_start_ovf, bus.err_orphan_done, bus.drained}, 0);
        reset = 0;

        // Basic
        do_reset();
        idle_to(10);
        bus.ap_start = 1; bus.ap_ready = 1;
        cyc();
        idle_to(25);
        bus.ap_done = 1;
        cyc();
        idle_in();
        chk_rec("basic", 0, 10, 25, 15);
        cyc();

        // Wait-ready, with ap_start dropped before ready
        do_reset();
        idle_to(5);
        bus.ap_start = 1;
        cyc();
        idle_to(8);
        bus.ap_ready = 1;
        cyc();
        idle_to(12);
        bus.ap_done = 1;
        cyc();
        idle_in();
        chk_rec("waitrdy", 0, 5, 12, 7);

        // Overlap then start-queue overflow
        do_reset();
        while (m_cnt < 36) begin
            idle_in();
            if (m_cnt inside {10, 12, 14, 30, 31, 32, 33, 34}) begin
                bus.ap_start = 1; bus.ap_ready = 1;
            end
            if (m_cnt inside {20, 22, 24}) bus.ap_done = 1;
            cyc();
            if (m_cnt inside {21, 23, 25})
                chk_rec("overlap", 16'((m_cnt - 21) / 2), m_cnt - 11, m_cnt - 1, 10);
            if (m_cnt == 34) chk("ovf_at4", bus.err_start_ovf, 0);
            if (m_cnt == 35) chk("ovf_at5", bus.err_start_ovf, 1);
        end

        // Backpressure with drops, then in-order drain
        do_reset();
        bus.rec_ready = 0;
        for (int i = 0; i < 10; i++) begin
            bus.ap_start = 1; bus.ap_ready = 1; bus.ap_done = 1;
            cyc();
        end
        idle_in();
        chk("bp_drop", bus.rec_drop_cnt, 2);
        bus.rec_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk_rec("bp_drain", 16'(i), 32'(i), 32'(i), 0);
            cyc();
        end
        chk("bp_empty", bus.rec_valid, 0);

        // Table: zero latency, orphan, bypass from WAIT_READY, queued pop
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.ap_start = vecs[i].st; bus.ap_ready = vecs[i].rdy; bus.ap_done = vecs[i].dn;
            cyc();
            chk($sformatf("vec%0d_valid", i), bus.rec_valid, vecs[i].ev);
            chk($sformatf("vec%0d_orph", i), bus.err_orphan_done, vecs[i].eorph);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_id", i), bus.rec_data[111:96], vecs[i].eid);
                chk($sformatf("vec%0d_lat", i), bus.rec_data[31:0], vecs[i].elat);
            end
        end
        idle_in();

        // Finish / drain
        do_reset();
        bus.rec_ready = 0;
        repeat (2) begin
            bus.ap_start = 1; bus.ap_ready = 1; bus.ap_done = 1;
            cyc();
        end
        idle_in();
        bus.finish = 1;
        cyc();
        bus.finish = 0;
        chk("fin_drained0", bus.drained, 0);
        bus.rec_ready = 1;
        cyc();
        chk("fin_drained1", bus.drained, 0);
        cyc();
        chk("fin_drained2", bus.drained, 1);

        // Reset with a stamp in flight
        bus.ap_start = 1; bus.ap_ready = 1;
        cyc();
        idle_in();
        reset = 1;
        cyc();
        reset = 0;
        chk("rst_outputs", {bus.rec_valid, bus.rec_drop_cnt, bus.err_start_ovf, bus.err_orphan_done, bus.drained}, 0);
        chk("rst_data", bus.rec_data, 0);
        bus.ap_done = 1;
        cyc();
        idle_in();
        chk("rst_no_rec", bus.rec_valid, 0);
        chk("rst_orphan", bus.err_orphan_done, 1);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.ap_start = $urandom_range(0, 2) == 0;
            bus.ap_ready = $urandom_range(0, 1) == 0;
            bus.ap_done = $urandom_range(0, 2) == 0;
            bus.ap_continue = $urandom_range(0, 4) != 0;
            bus.rec_ready = $urandom_range(0, 4) < 3;
            bus.finish = $urandom_range(0, 199) == 0;
            reset = $urandom_range(0, 999) == 0;
            cyc();
        end
        reset = 0;
        idle_in();
        bus.ap_continue = 1;
        cyc();

        // Counter wrap on the 8-bit instance
        rst8 = 1;
        cyc();
        rst8 = 0;
        while (c8 != 250) cyc();
        bus8.ap_start = 1; bus8.ap_ready = 1;
        cyc();
        bus8.ap_start = 0; bus8.ap_ready = 0;
        while (c8 != 260) cyc();
        bus8.ap_done = 1;
        cyc();
        bus8.ap_done = 0;
        chk("wrap_valid", bus8.rec_valid, 1);
        chk("wrap_rec", bus8.rec_data, {16'd0, 8'd250, 8'd4, 8'd10});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
